// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and sizing for the D-cache port arbiter.
// LOAD_STORE_SIZE mirrors the load/store queue depth used across the core.
package dcache_port_arbiter_pkg;

    localparam int LOAD_STORE_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_STORE,
        SERVE_LOAD,
        MISS_WAIT
    } arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Bundle between the arbiter, the load/store queue heads and the D-cache port.
// master is the arbiter side, slave is the queue/cache side.
interface dcache_port_arbiter_if
    import dcache_port_arbiter_pkg::*;
#(
    parameter int CNT_W = $clog2(LOAD_STORE_SIZE) + 1
) ();

    logic             store_commit;
    logic             store_head_valid;
    logic             load_head_valid;
    logic             load_head_blocked;
    logic             load_bypass_hit;
    logic             flush;
    logic             dc_resp_valid;
    logic             dc_miss;
    logic             dc_req_valid;
    logic             dc_req_is_store;
    logic             load_pop;
    logic             store_pop;
    logic [CNT_W-1:0] pend_cnt;
    logic             commit_stall;
    logic             busy;

    modport master (
        input  store_commit, store_head_valid, load_head_valid, load_head_blocked,
        input  load_bypass_hit, flush, dc_resp_valid, dc_miss,
        output dc_req_valid, dc_req_is_store, load_pop, store_pop,
        output pend_cnt, commit_stall, busy
    );

    modport slave (
        output store_commit, store_head_valid, load_head_valid, load_head_blocked,
        output load_bypass_hit, flush, dc_resp_valid, dc_miss,
        input  dc_req_valid, dc_req_is_store, load_pop, store_pop,
        input  pend_cnt, commit_stall, busy
    );

endinterface

// File: rtl/dcache_port_arbiter.sv
// Stateful arbiter for the single D-cache port: load queue head vs committed-store drain,
// with miss wait, store starvation protection and flush-kill of in-flight loads.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int LSQ_DEPTH    = LOAD_STORE_SIZE,
    parameter int CNT_W        = $clog2(LSQ_DEPTH) + 1,
    parameter int HIGH_WATER   = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_port_arbiter_if.master bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             kill_q, kill_d;
    logic             is_store_q, is_store_d;

    logic load_ready, store_ready, starved, high_water, stall;
    logic req, req_store, lpop, spop, commit_ok;

    assign load_ready  = bus.load_head_valid & ~bus.load_head_blocked & ~bus.flush;
    assign store_ready = bus.store_head_valid & (pend_q != '0);
    assign starved     = (starve_q >= SW'(STARVE_LIMIT));
    assign high_water  = (pend_q >= CNT_W'(HIGH_WATER));
    assign stall       = (pend_q == CNT_W'(LSQ_DEPTH));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        kill_d     = kill_q;
        is_store_d = is_store_q;
        req        = 1'b0;
        req_store  = 1'b0;
        lpop       = 1'b0;
        spop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ready && bus.load_bypass_hit) begin
                    lpop = 1'b1;
                end else if (store_ready && (high_water || !load_ready || starved)) begin
                    req        = 1'b1;
                    req_store  = 1'b1;
                    is_store_d = 1'b1;
                    starve_d   = '0;
                    state_d    = SERVE_STORE;
                end else if (load_ready) begin
                    req        = 1'b1;
                    is_store_d = 1'b0;
                    state_d    = SERVE_LOAD;
                    if (pend_q != '0 && !starved) starve_d = starve_q + SW'(1);
                end
            end
            default: begin
                // A flushed load still completes in the cache; only its pop is dropped.
                if (bus.dc_resp_valid) begin
                    if (is_store_q)                  spop = 1'b1;
                    else if (!kill_q && !bus.flush)  lpop = 1'b1;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (state_q != MISS_WAIT && bus.dc_miss) state_d = MISS_WAIT;
                    if (!is_store_q && bus.flush)            kill_d  = 1'b1;
                end
            end
        endcase
        if (bus.flush) starve_d = '0;
    end

    // A commit arriving while full is only accepted if a drain frees a slot in the same cycle.
    assign commit_ok = bus.store_commit & (~stall | spop);

    always_comb begin
        case ({commit_ok, spop})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            starve_q   <= '0;
            kill_q     <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            starve_q   <= starve_d;
            kill_q     <= kill_d;
            is_store_q <= is_store_d;
        end
    end

    assign bus.dc_req_valid    = req & ~rst;
    assign bus.dc_req_is_store = req_store & ~rst;
    assign bus.load_pop        = lpop & ~rst;
    assign bus.store_pop       = spop & ~rst;
    assign bus.pend_cnt        = pend_q;
    assign bus.commit_stall    = stall;
    assign bus.busy            = (state_q != IDLE);

    commit_while_full: assert property (@(posedge clk) disable iff (rst)
        !(bus.store_commit && stall && !spop));

    resp_while_idle: assert property (@(posedge clk) disable iff (rst)
        !((state_q == IDLE) && (bus.dc_resp_valid || bus.dc_miss)));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: inputs change 1ns after posedge,
// outputs are checked mid-cycle before the next posedge.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    localparam int CNT_W = $clog2(LOAD_STORE_SIZE) + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dcache_port_arbiter_if #(.CNT_W(CNT_W)) bus ();

    dcache_port_arbiter #(
        .LSQ_DEPTH   (LOAD_STORE_SIZE),
        .CNT_W       (CNT_W),
        .HIGH_WATER  (6),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Argument order: commit, store_head_valid, load_head_valid, blocked, bypass, flush, resp, miss.
    task automatic applyStimulus(input logic sc, input logic shv, input logic lhv, input logic lhb,
                                 input logic lbh, input logic fl, input logic rv, input logic ms);
        bus.store_commit      = sc;
        bus.store_head_valid  = shv;
        bus.load_head_valid   = lhv;
        bus.load_head_blocked = lhb;
        bus.load_bypass_hit   = lbh;
        bus.flush             = fl;
        bus.dc_resp_valid     = rv;
        bus.dc_miss           = ms;
        #4;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("reset req", bus.dc_req_valid, 0);
        checkOutput("reset load_pop", bus.load_pop, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset pend_cnt", bus.pend_cnt, 0);
        checkOutput("reset commit_stall", bus.commit_stall, 0);
        tick();
        rst = 1'b0;

        $display("[TB] single load hit");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("load req", bus.dc_req_valid, 1);
        checkOutput("load req is_store", bus.dc_req_is_store, 0);
        checkOutput("load busy before grant", bus.busy, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
        checkOutput("load hit pop", bus.load_pop, 1);
        checkOutput("no req while serving", bus.dc_req_valid, 0);
        checkOutput("busy while serving", bus.busy, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle after hit", bus.busy, 0);
        tick();

        $display("[TB] bypass, flush and blocked in IDLE");
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
        checkOutput("bypass pop", bus.load_pop, 1);
        checkOutput("bypass no req", bus.dc_req_valid, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 1, 1, 0, 0);
        checkOutput("flush kills bypass pop", bus.load_pop, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
        checkOutput("flush blocks load grant", bus.dc_req_valid, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("blocked load no req", bus.dc_req_valid, 0);
        checkOutput("blocked stays idle", bus.busy, 0);
        tick();

        $display("[TB] store priority at high water");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("pend after six commits", bus.pend_cnt, 6);
        checkOutput("high water req", bus.dc_req_valid, 1);
        checkOutput("high water is_store", bus.dc_req_is_store, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("store resp pop", bus.store_pop, 1);
        checkOutput("store resp no load_pop", bus.load_pop, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend after one drain", bus.pend_cnt, 5);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
            tick();
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend after drain to one", bus.pend_cnt, 1);
        tick();

        $display("[TB] starvation");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("starve load grant %0d", g), bus.dc_req_is_store, 0);
            checkOutput($sformatf("starve load req %0d", g), bus.dc_req_valid, 1);
            tick();
            applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
            checkOutput($sformatf("starve load pop %0d", g), bus.load_pop, 1);
            tick();
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("forced store req", bus.dc_req_valid, 1);
        checkOutput("forced store is_store", bus.dc_req_is_store, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("forced store pop", bus.store_pop, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("pend refilled", bus.pend_cnt, 1);
        checkOutput("starve reset load wins", bus.dc_req_is_store, 0);
        checkOutput("starve reset req", bus.dc_req_valid, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("post starve load pop", bus.load_pop, 1);
        tick();

        $display("[TB] load miss");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("miss load req", bus.dc_req_valid, 1);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
        checkOutput("miss no pop", bus.load_pop, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("miss wait no req %0d", i), bus.dc_req_valid, 0);
            checkOutput($sformatf("miss wait busy %0d", i), bus.busy, 1);
            tick();
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("refill load pop", bus.load_pop, 1);
        checkOutput("refill no store pop", bus.store_pop, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle after refill", bus.busy, 0);
        tick();

        $display("[TB] flush during load miss");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("flushmiss req", bus.dc_req_valid, 1);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush in miss busy", bus.busy, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("killed load no pop", bus.load_pop, 0);
        checkOutput("killed load no store pop", bus.store_pop, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("store after kill req", bus.dc_req_valid, 1);
        checkOutput("store after kill is_store", bus.dc_req_is_store, 1);
        checkOutput("idle after kill", bus.busy, 0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("store after kill pop", bus.store_pop, 1);
        tick();

        $display("[TB] flush with response on a load");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 1, 1, 0);
        checkOutput("flush+resp no pop", bus.load_pop, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush+resp idle", bus.busy, 0);
        checkOutput("pend drained", bus.pend_cnt, 0);
        tick();

        $display("[TB] counter boundary");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend seven", bus.pend_cnt, 7);
        checkOutput("no stall at seven", bus.commit_stall, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pend full", bus.pend_cnt, 8);
        checkOutput("stall at full", bus.commit_stall, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("full store req", bus.dc_req_is_store, 1);
        tick();
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("commit+pop store_pop", bus.store_pop, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("commit+pop pend", bus.pend_cnt, 8);
        tick();

        $display("[TB] reset mid store");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("pre-reset store req", bus.dc_req_valid, 1);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("serving store busy", bus.busy, 1);
        rst = 1'b1;
        bus.dc_resp_valid = 1'b1;
        #1;
        checkOutput("reset req", bus.dc_req_valid, 0);
        checkOutput("reset is_store", bus.dc_req_is_store, 0);
        checkOutput("reset load_pop", bus.load_pop, 0);
        checkOutput("reset store_pop", bus.store_pop, 0);
        checkOutput("reset pend", bus.pend_cnt, 0);
        checkOutput("reset stall", bus.commit_stall, 0);
        checkOutput("reset busy", bus.busy, 0);
        bus.dc_resp_valid    = 1'b0;
        bus.store_head_valid = 1'b0;
        bus.load_head_valid  = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
